// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared parity mode encodings and parity-error helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package parity_pkg;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Widest word the generic helper accepts; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    localparam int PARITY_MAX_W = 64;

    // Error bit from an already-reduced parity value.
    function automatic logic err_from_parity(input logic p, input logic odd_mode);
        return (odd_mode == MODE_ODD) ? ~p : p;
    endfunction

    function automatic logic parity_err(input logic [PARITY_MAX_W-1:0] data,
                                        input logic                    odd_mode);
        return err_from_parity(^data, odd_mode);
    endfunction

endpackage : parity_pkg

`default_nettype wire

// File: rtl/parity_reduce.sv
// ============================================================================
// Module      : parity_reduce
// Description : Combinational XOR reduction of a W-bit word to one bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module parity_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    output logic         parity
);

    assign parity = ^data;

endmodule : parity_reduce

`default_nettype wire

// File: rtl/parity_check_stream.sv
// ============================================================================
// Module      : parity_check_stream
// Description : Streaming parity checker with valid/ready handshake, one-deep
//               registered output stage and saturating error statistics.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module parity_check_stream
    import parity_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             parity;
    logic             word_err;
    logic             take;
    logic [CNT_W-1:0] err_base;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] word_cnt_nxt;
    logic             sticky_nxt;

    parity_reduce #(
        .W (DATA_W + 1)
    ) u_reduce (
        .data   (in_data),
        .parity (parity)
    );

    assign word_err = err_from_parity(parity, odd_mode);

    // Output slot frees up in the same cycle it is drained, so a full stream
    // runs without bubbles.
    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[DATA_W-1:0];
            out_err   <= word_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear is applied first so a same-cycle error is still recorded.
    always_comb begin
        err_base     = err_clr ? '0 : err_cnt;
        err_cnt_nxt  = err_base;
        word_cnt_nxt = word_cnt;
        sticky_nxt   = (err_clr ? 1'b0 : err_sticky) | (take & word_err);
        if (take && word_err && (err_base != CNT_MAX)) begin
            err_cnt_nxt = err_base + CNT_ONE;
        end
        if (take && (word_cnt != CNT_MAX)) begin
            word_cnt_nxt = word_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt    <= '0;
            word_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_cnt    <= err_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            err_sticky <= sticky_nxt;
        end
    end

endmodule : parity_check_stream

`default_nettype wire

// File: tb/tb_parity_check_stream.sv
// ============================================================================
// Module      : tb_parity_check_stream
// Description : Directed self-checking bench for parity_check_stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_parity_check_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        odd_mode;
    logic        in_valid;
    logic        s_in_valid;
    logic        out_ready;
    logic        err_clr;
    logic [7:0]  in_data;

    logic        in_ready, out_valid, out_err, err_sticky;
    logic [6:0]  out_data;
    logic [15:0] err_cnt, word_cnt;

    logic        s_in_ready, s_out_valid, s_out_err, s_err_sticky;
    logic [6:0]  s_out_data;
    logic [1:0]  s_err_cnt, s_word_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    parity_check_stream #(.DATA_W(7), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_clr(err_clr), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    parity_check_stream #(.DATA_W(7), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .odd_mode(odd_mode),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_err(s_out_err), .err_clr(err_clr), .err_sticky(s_err_sticky),
        .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; odd_mode = 1'b1; in_valid = 1'b0; s_in_valid = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0; in_data = 8'h00;
        step(); step();
        rst = 1'b0;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b0) $display("FAIL reset_sticky got=%b exp=0", err_sticky); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd0) $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (s_word_cnt !== 2'd0) $display("FAIL reset_sat_word_cnt got=%0d exp=0", s_word_cnt); else pass_cnt++;
    endtask

    task automatic test_basic();
        odd_mode = 1'b1; in_data = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h01) $display("FAIL basic_out_data got=%h exp=01", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL basic_out_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd0) $display("FAIL basic_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd1) $display("FAIL basic_word_cnt got=%0d exp=1", word_cnt); else pass_cnt++;
    endtask

    task automatic test_mode();
        odd_mode = 1'b1; in_data = 8'h81; in_valid = 1'b1;
        step();
        total_cnt++; if (out_err !== 1'b1) $display("FAIL odd81_out_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h01) $display("FAIL odd81_out_data got=%h exp=01", out_data); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b1) $display("FAIL odd81_sticky got=%b exp=1", err_sticky); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd1) $display("FAIL odd81_err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        odd_mode = 1'b0; in_data = 8'h81;
        step();
        total_cnt++; if (out_err !== 1'b0) $display("FAIL even81_out_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b1) $display("FAIL even81_sticky_held got=%b exp=1", err_sticky); else pass_cnt++;
        in_data = 8'h01;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_err !== 1'b1) $display("FAIL even01_out_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd2) $display("FAIL even01_err_cnt got=%0d exp=2", err_cnt); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd4) $display("FAIL mode_word_cnt got=%0d exp=4", word_cnt); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL retire_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; odd_mode = 1'b1; in_data = 8'h03; in_valid = 1'b1;
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h03) $display("FAIL bp_first_data got=%h exp=03", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b1) $display("FAIL bp_first_err got=%b exp=1", out_err); else pass_cnt++;
        in_data = 8'h05; odd_mode = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (out_data !== 7'h03) $display("FAIL bp_hold_data got=%h exp=03", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b1) $display("FAIL bp_hold_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd5) $display("FAIL bp_stall_word_cnt got=%0d exp=5", word_cnt); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h05) $display("FAIL bp_second_data got=%h exp=05", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL bp_second_err got=%b exp=0", out_err); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd6) $display("FAIL bp_word_cnt got=%0d exp=6", word_cnt); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd3) $display("FAIL bp_err_cnt got=%0d exp=3", err_cnt); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_err;
        logic [7:0] word;
        exp_err   = 4'b0110;
        out_ready = 1'b1; odd_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word     = 8'h10 + 8'(i);
            in_data  = word;
            in_valid = 1'b1;
            step();
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); else pass_cnt++;
            total_cnt++; if (out_data !== word[6:0]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, word[6:0]); else pass_cnt++;
            total_cnt++; if (out_err !== exp_err[i]) $display("FAIL b2b_err[%0d] got=%b exp=%b", i, out_err, exp_err[i]); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++; if (word_cnt !== 16'd10) $display("FAIL b2b_word_cnt got=%0d exp=10", word_cnt); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd5) $display("FAIL b2b_err_cnt got=%0d exp=5", err_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        odd_mode = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_in_valid = 1'b1;
            step();
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
            total_cnt++; if (s_err_cnt !== exp_cnt) $display("FAIL sat_err_cnt[%0d] got=%0d exp=%0d", k, s_err_cnt, exp_cnt); else pass_cnt++;
            total_cnt++; if (s_word_cnt !== exp_cnt) $display("FAIL sat_word_cnt[%0d] got=%0d exp=%0d", k, s_word_cnt, exp_cnt); else pass_cnt++;
        end
        s_in_valid = 1'b0;
        total_cnt++; if (word_cnt !== 16'd10) $display("FAIL sat_main_untouched got=%0d exp=10", word_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1; odd_mode = 1'b1; in_data = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++; if (err_cnt !== 16'd1) $display("FAIL clr_err_same_cycle_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b1) $display("FAIL clr_err_same_cycle_sticky got=%b exp=1", err_sticky); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd11) $display("FAIL clr_word_cnt_a got=%0d exp=11", word_cnt); else pass_cnt++;
        step();
        err_clr = 1'b0;
        total_cnt++; if (err_cnt !== 16'd0) $display("FAIL clr_alone_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b0) $display("FAIL clr_alone_sticky got=%b exp=0", err_sticky); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd11) $display("FAIL clr_word_cnt_b got=%0d exp=11", word_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        odd_mode = 1'b0; in_data = 8'h04; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL arst_pre_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd1) $display("FAIL arst_pre_err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        #3;
        rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h00) $display("FAIL arst_out_data got=%h exp=00", out_data); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd0) $display("FAIL arst_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd0) $display("FAIL arst_word_cnt got=%0d exp=0", word_cnt); else pass_cnt++;
        total_cnt++; if (err_sticky !== 1'b0) $display("FAIL arst_sticky got=%b exp=0", err_sticky); else pass_cnt++;
        step();
        rst = 1'b0;
        odd_mode = 1'b1; in_data = 8'h81; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL post_rst_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 7'h01) $display("FAIL post_rst_data got=%h exp=01", out_data); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b1) $display("FAIL post_rst_err got=%b exp=1", out_err); else pass_cnt++;
        total_cnt++; if (err_cnt !== 16'd1) $display("FAIL post_rst_err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        total_cnt++; if (word_cnt !== 16'd1) $display("FAIL post_rst_word_cnt got=%0d exp=1", word_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode();
        test_backpressure();
        test_back_to_back();
        test_saturate();
        test_err_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_parity_check_stream

`default_nettype wire
